adder16_arbiter: RTL

- Shares one Adder16 instance between NREQ requesters, using round-robin arbitration.
- Supports two operation widths:
  - 16-bit add, one adder pass.
  - 32-bit add, two adder passes: low half first, then high half with the low-half carry chained in.
- Presents a single registered response port with backpressure.
- Sits between integer-unit clients (ALU, address generation, accumulator) and the shared adder datapath.

---
 rtl/adder16_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/adder16_arbiter.sv
// rtl/adder16_arbiter.sv - round-robin arbiter sharing one 16-bit adder for 16/32-bit adds
//
// adder16 ports:
//   x, y      16-bit addends
//   cin       carry-in
//   sum       16-bit sum
//   cout      carry-out of bit 15
//
// adder16_arbiter ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[NREQ]     per-requester request valid
//   req_ready[NREQ]     per-requester accept strobe (combinational, one-hot or zero, IDLE only)
//   req_wide[NREQ]      1 = 32-bit op (two adder passes), 0 = 16-bit op
//   req_cin[NREQ]       per-requester carry-in
//   req_a, req_b        packed 32-bit operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready response handshake
//   rsp_id              owner of the response
//   rsp_sum, rsp_carry  result and carry-out (bit 15 or bit 31)
//   busy                high whenever an operation is in flight or waiting to be consumed

module adder16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {16'h0000, cin};
endmodule

module adder16_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_wide,
  input  logic [NREQ-1:0]    req_cin,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_sum,
  output logic               rsp_carry,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           found;
  logic [31:0]    sel_a, sel_b;

  logic [31:0]    a_q, b_q;
  logic           wide_q, cin_q;
  logic [IDW-1:0] id_q;
  logic [15:0]    sum_lo_q;
  logic           carry_lo_q;

  logic [15:0]    add_x, add_y, add_sum;
  logic           add_cin, add_cout;

  // Scan from rr_ptr upward with wrap; iterating k downward lets the
  // smallest offset (closest to rr_ptr) be the last and winning assignment.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        winner = IDW'((int'(rr_ptr) + k) % NREQ);
        found  = 1'b1;
      end
    end
  end

  assign sel_a = req_a[32*winner +: 32];
  assign sel_b = req_b[32*winner +: 32];

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = LO;
      LO:      state_nx = wide_q ? HI : RESP;
      HI:      state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Adder inputs are forced to zero outside LO/HI so the datapath stays quiet.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (state)
      LO: begin
        add_x   = a_q[15:0];
        add_y   = b_q[15:0];
        add_cin = cin_q;
      end
      HI: begin
        add_x   = a_q[31:16];
        add_y   = b_q[31:16];
        add_cin = carry_lo_q;
      end
      default: ;
    endcase
  end

  adder16 u_adder (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      wide_q     <= 1'b0;
      cin_q      <= 1'b0;
      id_q       <= '0;
      sum_lo_q   <= '0;
      carry_lo_q <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          a_q    <= sel_a;
          b_q    <= sel_b;
          wide_q <= req_wide[winner];
          cin_q  <= req_cin[winner];
          id_q   <= winner;
          rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
        LO: begin
          sum_lo_q   <= add_sum;
          carry_lo_q <= add_cout;
          if (!wide_q) begin
            rsp_sum   <= {16'h0000, add_sum};
            rsp_carry <= add_cout;
            rsp_id    <= id_q;
          end
        end
        HI: begin
          rsp_sum   <= {add_sum, sum_lo_q};
          rsp_carry <= add_cout;
          rsp_id    <= id_q;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule
